// File: rtl/ser_pkg.sv
// ser_pkg: shared types and helpers for the parallel-in/serial-out serializer.
//   ser_state_t      : serializer FSM states (PARITY only used with SER_PARITY_EN)
//   cnt_w()          : width of the remaining-bits counter for a given word width
//   SER_IDLE_DEFAULT : default level of the serial line between frames
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam logic SER_IDLE_DEFAULT = 1'b0;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out stage feeding a serial shift-register
// chain. Words are taken over a valid/ready handshake and shifted out MSB first,
// one bit per clk, with a one-cycle frame_start marker on the MSB. Back-to-back
// words stream without an idle gap.
//
// Optional build macro SER_PARITY_EN: appends one even-parity bit (XOR of the
// accepted word) after the data bits, making frames WIDTH+1 bits long.
//
// Parameters:
//   WIDTH     data word width (>= 2)
//   IDLE_BIT  level on so while no frame is active
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   din          parallel word to serialize
//   din_valid    din holds a valid word
//   din_ready    word is accepted on this cycle if din_valid is high
//   so           serial data out (MSB first)
//   so_valid     so carries a frame bit
//   frame_start  so carries the first bit of a frame
module piso_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = SER_IDLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             so_valid,
  output logic             frame_start
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] REM_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] REM_ONE  = CW'(1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    rem;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             parity;
`endif

  // Ready depends only on state and counter so it never loops back through
  // din_valid. Without parity the last data bit can overlap the next accept,
  // which is what makes back-to-back frames gapless.
  always_comb begin
    din_ready = 1'b0;
    case (state)
      IDLE:   din_ready = 1'b1;
`ifdef SER_PARITY_EN
      PARITY: din_ready = 1'b1;
`else
      DATA:   din_ready = (rem == '0);
`endif
      default: din_ready = 1'b0;
    endcase
  end

  assign accept = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      rem         <= '0;
      so          <= IDLE_BIT;
      so_valid    <= 1'b0;
      frame_start <= 1'b0;
`ifdef SER_PARITY_EN
      parity      <= 1'b0;
`endif
    end else if (accept) begin
      // MSB goes straight to so; the shift register keeps the remaining bits.
      state       <= DATA;
      so          <= din[WIDTH-1];
      so_valid    <= 1'b1;
      frame_start <= 1'b1;
      shreg       <= {din[WIDTH-2:0], 1'b0};
      rem         <= REM_LOAD;
`ifdef SER_PARITY_EN
      parity      <= ^din;
`endif
    end else begin
      frame_start <= 1'b0;
      case (state)
        DATA: begin
          if (rem != '0) begin
            so       <= shreg[WIDTH-1];
            so_valid <= 1'b1;
            shreg    <= {shreg[WIDTH-2:0], 1'b0};
            rem      <= rem - REM_ONE;
          end else begin
`ifdef SER_PARITY_EN
            state    <= PARITY;
            so       <= parity;
            so_valid <= 1'b1;
`else
            state    <= IDLE;
            so       <= IDLE_BIT;
            so_valid <= 1'b0;
`endif
          end
        end
        default: begin
          // IDLE with nothing to take, or the parity bit has just been sent.
          state    <= IDLE;
          so       <= IDLE_BIT;
          so_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer (WIDTH = 8), with a
// downstream serial shift register (SIZE = 8) attached to so as a loopback.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       so;
  logic       so_valid;
  logic       frame_start;

  int vecs = 0;
  int errs = 0;

  logic [7:0] ds;
  logic [7:0] pat;
  logic [7:0] pat2;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .so         (so),
    .so_valid   (so_valid),
    .frame_start(frame_start)
  );

  // Downstream serial stage: first received bit ends up in ds[7].
  always @(posedge clk) begin
    if (so_valid) ds <= {ds[6:0], so};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_so"}, {7'd0, so}, 8'd0);
    chk({tag, "_vld"}, {7'd0, so_valid}, 8'd0);
    chk({tag, "_fs"}, {7'd0, frame_start}, 8'd0);
    chk({tag, "_rdy"}, {7'd0, din_ready}, 8'd1);
  endtask

  initial begin
    // Reset
    step();
    step();
    chk_idle("rst");
    rst_n = 1'b1;
    step();
    chk_idle("post_rst");

    // Single word A5
    pat = 8'hA5;
    din = pat;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) step();
      chk("a5_bit", {7'd0, so}, {7'd0, pat[8-c]});
      chk("a5_vld", {7'd0, so_valid}, 8'd1);
      chk("a5_fs", {7'd0, frame_start}, (c == 1) ? 8'd1 : 8'd0);
    end
`ifdef SER_PARITY_EN
    step();
    chk("a5_par", {7'd0, so}, 8'd0);
    chk("a5_par_vld", {7'd0, so_valid}, 8'd1);
    chk("a5_par_fs", {7'd0, frame_start}, 8'd0);
`endif
    step();
    chk_idle("a5_end");

`ifndef SER_PARITY_EN
    // Back-to-back FF then 00 with din_valid held
    din = 8'hFF;
    din_valid = 1'b1;
    chk("b2b_rdy0", {7'd0, din_ready}, 8'd1);
    step();
    din = 8'h00;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) step();
      if (c == 10) din_valid = 1'b0;
      chk("b2b_vld", {7'd0, so_valid}, 8'd1);
      chk("b2b_bit", {7'd0, so}, (c <= 8) ? 8'd1 : 8'd0);
      chk("b2b_fs", {7'd0, frame_start}, (c == 1 || c == 9) ? 8'd1 : 8'd0);
      chk("b2b_rdy", {7'd0, din_ready}, (c == 8 || c == 16) ? 8'd1 : 8'd0);
    end
    din_valid = 1'b0;
    step();
    chk_idle("b2b_end");

    // Mid-frame din_valid pulse must be ignored; held valid waits for ready
    pat = 8'hC3;
    pat2 = 8'h81;
    din = pat;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) step();
      if (c <= 8) chk("ign_bit", {7'd0, so}, {7'd0, pat[8-c]});
      else chk("ign_bit2", {7'd0, so}, {7'd0, pat2[16-c]});
      chk("ign_fs", {7'd0, frame_start}, (c == 1 || c == 9) ? 8'd1 : 8'd0);
      chk("ign_vld", {7'd0, so_valid}, 8'd1);
      if (c == 3) begin
        din = 8'h55;
        din_valid = 1'b1;
        chk("ign_rdy", {7'd0, din_ready}, 8'd0);
      end
      if (c == 4) din_valid = 1'b0;
      if (c == 5) begin
        din = pat2;
        din_valid = 1'b1;
      end
      if (c == 8) chk("ign_rdy8", {7'd0, din_ready}, 8'd1);
      if (c == 9) din_valid = 1'b0;
    end
    step();
    chk_idle("ign_end");
`else
    // Parity: 07 twice back to back, 9-bit frames, parity bit 1
    pat = 8'h07;
    din = pat;
    din_valid = 1'b1;
    step();
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) step();
      if (c == 10) din_valid = 1'b0;
      chk("par_vld", {7'd0, so_valid}, 8'd1);
      if (c == 9 || c == 18) chk("par_bit", {7'd0, so}, 8'd1);
      else if (c < 9) chk("par_d1", {7'd0, so}, {7'd0, pat[8-c]});
      else chk("par_d2", {7'd0, so}, {7'd0, pat[17-c]});
      chk("par_fs", {7'd0, frame_start}, (c == 1 || c == 10) ? 8'd1 : 8'd0);
      chk("par_rdy", {7'd0, din_ready}, (c == 9 || c == 18) ? 8'd1 : 8'd0);
    end
    din_valid = 1'b0;
    step();
    chk_idle("par_end");
`endif

    // Loopback into the downstream stage
    din = 8'h3C;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 2; c <= 9; c++) step();
    chk("loop_ds", ds, 8'h3C);
    step();
    step();
    chk_idle("loop_end");

    // Reset in the middle of a frame
    din = 8'hF0;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    step();
    chk("mid_vld", {7'd0, so_valid}, 8'd1);
    rst_n = 1'b0;
    step();
    chk_idle("mid_rst");
    rst_n = 1'b1;
    step();
    chk_idle("mid_rst_after");
    step();
    chk_idle("mid_rst_after2");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
